spi_mem_bridge: RTL and testbench

- Turns the SPI target's received byte stream into framed memory read/write commands for the on-chip memories (VRAM, font RAM, future targets).
- Generalises the existing "SPI byte → font RAM at an incrementing address" test path. Adds parametrised address and data widths, N selectable targets, explicit start addresses, streamed auto-incrementing reads and writes, and a req/ack handshake.
- Sits between spi_target and the memory arbiters in xosera_main.

---
 rtl/spi_mem_bridge.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_mem_bridge.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: turns framed SPI bytes into req/ack memory read/write commands.
// Optional build macro SPI_MEM_BRIDGE_STATUS_EN adds the 8'h8F status-byte command.
module spi_mem_bridge #(
    parameter int         ADDR_W      = 16,
    parameter int         DATA_W      = 16,
    parameter int         NUM_TARGETS = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h81
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              cs_n_i,
    input  logic              rx_strobe_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              tx_strobe_i,
    output logic [7:0]        tx_byte_o,
    output logic              mem_req_o,
    output logic              mem_wr_o,
    output logic [2:0]        mem_target_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o
);
    // state    | meaning
    // S_CMD    | waiting for the command byte of a frame
    // S_ADDR   | shifting in the start address, MSB first
    // S_WDATA  | assembling write words, one request per word
    // S_RDATA  | streaming read words out with one-word prefetch
    // S_DRAIN  | ignoring the rest of the frame
    // S_STATUS | status byte presented on tx (status build only)

    localparam int         ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int         DATA_BYTES = DATA_W / 8;
    localparam logic [2:0] ADDR_LAST  = 3'(ADDR_BYTES - 1);
    localparam logic [2:0] DATA_LAST  = 3'(DATA_BYTES - 1);
    localparam logic [2:0] DATA_FULL  = 3'(DATA_BYTES);
    localparam logic [3:0] TGT_LIMIT  = 4'(NUM_TARGETS);

    typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_RDATA, S_DRAIN, S_STATUS} state_t;

    state_t            state, state_nxt;
    logic              is_read;
    logic [2:0]        target;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        byte_cnt;
    logic [DATA_W-1:0] wbuf;
    logic              req, req_wr, req_live;
    logic [2:0]        req_target;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] tx_shift, rbuf;
    logic [2:0]        tx_cnt;
    logic              rbuf_valid, rd_want;
    logic              overrun, bad_target;

    logic [ADDR_W-1:0] addr_shift;
    logic [DATA_W-1:0] wdata_shift;
    logic cmd_bad, rx_cmd, rx_addr, rx_addr_last, rx_wdata, word_done;
    logic ack_live, rd_ack, tx_pop, tx_free, rd_issue;

    assign addr_shift   = ADDR_W'({addr, rx_byte_i});
    assign wdata_shift  = DATA_W'({wbuf, rx_byte_i});
    assign cmd_bad      = ({1'b0, rx_byte_i[6:4]} >= TGT_LIMIT);
    assign rx_cmd       = rx_strobe_i && !cs_n_i && (state == S_CMD);
    assign rx_addr      = rx_strobe_i && !cs_n_i && (state == S_ADDR);
    assign rx_addr_last = rx_addr && (byte_cnt == ADDR_LAST);
    assign rx_wdata     = rx_strobe_i && !cs_n_i && (state == S_WDATA);
    assign word_done    = rx_wdata && (byte_cnt == DATA_LAST);
    // Acks of requests left over from an earlier frame only retire the request.
    assign ack_live     = mem_ack_i && req && req_live && !cs_n_i;
    assign rd_ack       = ack_live && !req_wr;
    assign tx_pop       = tx_strobe_i && (tx_cnt != 3'd0);
    assign tx_free      = (tx_cnt == 3'd0) || (tx_pop && (tx_cnt == 3'd1));
    assign rd_issue     = (state == S_RDATA) && rd_want && !req && !rbuf_valid && !cs_n_i;

    always_ff @(posedge clk) begin
        if (reset_i) state <= S_CMD;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_n_i) begin
            state_nxt = S_CMD;
        end else begin
            case (state)
                S_CMD: if (rx_strobe_i) begin
                    if (cmd_bad) state_nxt = S_DRAIN;
`ifdef SPI_MEM_BRIDGE_STATUS_EN
                    else if (rx_byte_i == 8'h8F) state_nxt = S_STATUS;
`endif
                    else state_nxt = S_ADDR;
                end
                S_ADDR:   if (rx_strobe_i && (byte_cnt == ADDR_LAST))
                              state_nxt = is_read ? S_RDATA : S_WDATA;
                S_STATUS: if (tx_strobe_i) state_nxt = S_DRAIN;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            is_read    <= 1'b0;
            target     <= '0;
            addr       <= '0;
            byte_cnt   <= '0;
            wbuf       <= '0;
            req        <= 1'b0;
            req_wr     <= 1'b0;
            req_live   <= 1'b0;
            req_target <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
            tx_shift   <= '0;
            tx_cnt     <= '0;
            rbuf       <= '0;
            rbuf_valid <= 1'b0;
            rd_want    <= 1'b0;
            overrun    <= 1'b0;
            bad_target <= 1'b0;
        end else begin
            if (mem_ack_i && req) req <= 1'b0;
            if (ack_live) addr <= addr + ADDR_W'(1);
            if (rd_ack) rd_want <= 1'b1;

            if (rx_cmd) begin
                is_read  <= rx_byte_i[7];
                target   <= rx_byte_i[6:4];
                byte_cnt <= '0;
                if (cmd_bad) bad_target <= 1'b1;
            end

            if (rx_addr) begin
                addr     <= addr_shift;
                byte_cnt <= rx_addr_last ? 3'd0 : byte_cnt + 3'd1;
                if (rx_addr_last && is_read) begin
                    // A stale request from the previous frame must finish first.
                    if (req) begin
                        rd_want <= 1'b1;
                    end else begin
                        req        <= 1'b1;
                        req_wr     <= 1'b0;
                        req_addr   <= addr_shift;
                        req_target <= target;
                        req_live   <= 1'b1;
                    end
                end
            end

            if (rx_wdata) begin
                wbuf     <= wdata_shift;
                byte_cnt <= word_done ? 3'd0 : byte_cnt + 3'd1;
                if (word_done) begin
                    if (req) begin
                        overrun <= 1'b1;
                    end else begin
                        req        <= 1'b1;
                        req_wr     <= 1'b1;
                        req_addr   <= addr;
                        req_wdata  <= wdata_shift;
                        req_target <= target;
                        req_live   <= 1'b1;
                    end
                end
            end

            if (rd_issue) begin
                req        <= 1'b1;
                req_wr     <= 1'b0;
                req_addr   <= addr;
                req_target <= target;
                req_live   <= 1'b1;
                rd_want    <= 1'b0;
            end

            if (tx_pop) begin
                tx_shift <= tx_shift << 8;
                tx_cnt   <= tx_cnt - 3'd1;
            end
            if (tx_free && rbuf_valid) begin
                tx_shift   <= rbuf;
                tx_cnt     <= DATA_FULL;
                rbuf_valid <= 1'b0;
            end
            if (rd_ack) begin
                if (tx_free && !rbuf_valid) begin
                    tx_shift <= mem_rdata_i;
                    tx_cnt   <= DATA_FULL;
                end else begin
                    rbuf       <= mem_rdata_i;
                    rbuf_valid <= 1'b1;
                end
            end

`ifdef SPI_MEM_BRIDGE_STATUS_EN
            if ((state == S_STATUS) && tx_strobe_i && !cs_n_i) begin
                overrun    <= 1'b0;
                bad_target <= 1'b0;
            end
`endif

            if (cs_n_i) begin
                byte_cnt   <= '0;
                tx_cnt     <= '0;
                rbuf_valid <= 1'b0;
                rd_want    <= 1'b0;
                req_live   <= 1'b0;
            end
        end
    end

    always_comb begin
        tx_byte_o = IDLE_BYTE;
        if (tx_cnt != 3'd0) tx_byte_o = tx_shift[DATA_W-1 -: 8];
`ifdef SPI_MEM_BRIDGE_STATUS_EN
        if (state == S_STATUS) tx_byte_o = {overrun, bad_target, req, 5'b0};
`endif
    end

    assign mem_req_o    = req;
    assign mem_wr_o     = req_wr;
    assign mem_target_o = req_target;
    assign mem_addr_o   = req_addr;
    assign mem_wdata_o  = req_wdata;
    assign err_o        = overrun | bad_target;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Scoreboarded bench for spi_mem_bridge: expected requests and tx bytes are queued
// by the stimulus and checked by independent monitors.
module tb_spi_mem_bridge;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        cs_n_i = 1'b1;
    logic        rx_strobe_i = 1'b0;
    logic [7:0]  rx_byte_i = 8'h00;
    logic        tx_strobe_i = 1'b0;
    logic [7:0]  tx_byte_o;
    logic        mem_req_o;
    logic        mem_wr_o;
    logic [2:0]  mem_target_o;
    logic [15:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [15:0] mem_rdata_i = 16'h0000;
    logic        err_o;

    spi_mem_bridge dut (
        .clk(clk), .reset_i(reset_i), .cs_n_i(cs_n_i),
        .rx_strobe_i(rx_strobe_i), .rx_byte_i(rx_byte_i),
        .tx_strobe_i(tx_strobe_i), .tx_byte_o(tx_byte_o),
        .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_target_o(mem_target_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  tgt;
        logic [15:0] addr;
        logic [15:0] data;
    } req_t;

    req_t        req_q[$];
    logic [7:0]  tx_q[$];
    logic [15:0] rd_q[$];
    logic        ack_en = 1'b1;
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic req_t mk(input logic wr, input logic [2:0] tgt,
                                input logic [15:0] addr, input logic [15:0] data);
        req_t r;
        r.wr = wr; r.tgt = tgt; r.addr = addr; r.data = data;
        return r;
    endfunction

    // Memory responder: acks each request two cycles after it is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_o && ack_en && !reset_i) begin
                @(posedge clk); #1;
                mem_ack_i = 1'b1;
                if (!mem_wr_o && rd_q.size() > 0) mem_rdata_i = rd_q.pop_front();
                else                              mem_rdata_i = 16'h0000;
                @(posedge clk); #1;
                mem_ack_i = 1'b0;
            end
        end
    end

    // Request monitor: compares each acknowledged request with the scoreboard.
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            if (mem_req_o && mem_ack_i) begin
                if (req_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL req_unexpected: got wr=%0b tgt=%0d addr=%h data=%h expected none",
                             mem_wr_o, mem_target_o, mem_addr_o, mem_wdata_o);
                end else begin
                    e = req_q.pop_front();
                    check("req_wr",   32'(mem_wr_o),     32'(e.wr));
                    check("req_tgt",  32'(mem_target_o), 32'(e.tgt));
                    check("req_addr", 32'(mem_addr_o),   32'(e.addr));
                    if (e.wr) check("req_wdata", 32'(mem_wdata_o), 32'(e.data));
                end
            end
        end
    end

    // Tx monitor: the byte present when spi_target strobes is what it sends.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_strobe_i) begin
                if (tx_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL tx_unexpected: got %h expected none", tx_byte_o);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_byte", 32'(tx_byte_o), 32'(e));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_strobe_i = 1'b1; rx_byte_i = b;
        @(posedge clk); #1;
        rx_strobe_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic tx_pulse(input logic [7:0] exp);
        tx_q.push_back(exp);
        repeat (6) @(posedge clk);
        #1 tx_strobe_i = 1'b1;
        @(posedge clk); #1;
        tx_strobe_i = 1'b0;
    endtask

    task automatic cs_low;
        repeat (3) @(posedge clk);
        #1 cs_n_i = 1'b0;
    endtask

    task automatic cs_high;
        #0 cs_n_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk); #1 reset_i = 1'b1;
        @(posedge clk); #1 reset_i = 1'b0;
    endtask

    task automatic frame(input logic [7:0] bytes[], input int n);
        cs_low();
        for (int i = 0; i < n; i++) send_byte(bytes[i]);
        cs_high();
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while ((req_q.size() != 0 || mem_req_o) && cyc < 300) begin
            @(posedge clk); cyc++;
        end
        @(negedge clk);
        check(name, 32'(req_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] f[];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx",    32'(tx_byte_o),    32'h81);
        check("rst_req",   32'(mem_req_o),    32'd0);
        check("rst_wr",    32'(mem_wr_o),     32'd0);
        check("rst_tgt",   32'(mem_target_o), 32'd0);
        check("rst_addr",  32'(mem_addr_o),   32'd0);
        check("rst_wdata", 32'(mem_wdata_o),  32'd0);
        check("rst_err",   32'(err_o),        32'd0);
        #1 reset_i = 1'b0;

        // Two streamed writes to target 0.
        req_q.push_back(mk(1'b1, 3'd0, 16'h1234, 16'hABCD));
        req_q.push_back(mk(1'b1, 3'd0, 16'h1235, 16'hEF01));
        f = '{8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hEF, 8'h01};
        frame(f, 7);
        wait_idle("write_done");
        check("write_err", 32'(err_o), 32'd0);

        // Streamed read from target 1 with prefetch.
        ack_en = 1'b0;
        rd_q = '{16'h5A5A, 16'hC3C3, 16'hBEEF};
        req_q.push_back(mk(1'b0, 3'd1, 16'h0010, 16'h0000));
        req_q.push_back(mk(1'b0, 3'd1, 16'h0011, 16'h0000));
        req_q.push_back(mk(1'b0, 3'd1, 16'h0012, 16'h0000));
        cs_low();
        send_byte(8'h90);
        tx_pulse(8'h81);
        send_byte(8'h00);
        send_byte(8'h10);
        ack_en = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        tx_pulse(8'h5A);
        tx_pulse(8'h5A);
        tx_pulse(8'hC3);
        tx_pulse(8'hC3);
        cs_high();
        wait_idle("read_done");
        check("read_err", 32'(err_o), 32'd0);

        // Overrun: second word dropped, then reset with a request outstanding.
        ack_en = 1'b0;
        cs_low();
        f = '{8'h00, 8'h00, 8'h20, 8'h11, 8'h11, 8'h22, 8'h22};
        for (int i = 0; i < 7; i++) send_byte(f[i]);
        @(negedge clk);
        check("ovr_err",   32'(err_o),       32'd1);
        check("ovr_req",   32'(mem_req_o),   32'd1);
        check("ovr_wr",    32'(mem_wr_o),    32'd1);
        check("ovr_addr",  32'(mem_addr_o),  32'h0020);
        check("ovr_wdata", 32'(mem_wdata_o), 32'h1111);
        do_reset();
        @(negedge clk);
        check("midrst_req", 32'(mem_req_o), 32'd0);
        check("midrst_err", 32'(err_o),     32'd0);
        check("midrst_tx",  32'(tx_byte_o), 32'h81);
        #1 cs_n_i = 1'b1;
        ack_en = 1'b1;
        repeat (4) @(posedge clk);

        // Invalid targets: 7 and the first out-of-range index 2.
        f = '{8'h70, 8'h00, 8'h00, 8'h11, 8'h22};
        frame(f, 5);
        @(negedge clk);
        check("bad7_err", 32'(err_o),     32'd1);
        check("bad7_req", 32'(mem_req_o), 32'd0);
        do_reset();
        f = '{8'h20, 8'h00, 8'h00, 8'h11, 8'h22};
        frame(f, 5);
        @(negedge clk);
        check("bad2_err", 32'(err_o),     32'd1);
        check("bad2_req", 32'(mem_req_o), 32'd0);
        do_reset();

        // Address wrap from FFFF to 0000.
        req_q.push_back(mk(1'b1, 3'd0, 16'hFFFF, 16'h1111));
        req_q.push_back(mk(1'b1, 3'd0, 16'h0000, 16'h2222));
        f = '{8'h00, 8'hFF, 8'hFF, 8'h11, 8'h11, 8'h22, 8'h22};
        frame(f, 7);
        wait_idle("wrap_done");
        check("wrap_err", 32'(err_o), 32'd0);

        // Frame abort discards the partial word.
        f = '{8'h00, 8'h00, 8'h05, 8'hAA};
        frame(f, 4);
        req_q.push_back(mk(1'b1, 3'd0, 16'h0001, 16'h1122));
        f = '{8'h00, 8'h00, 8'h01, 8'h11, 8'h22};
        frame(f, 5);
        wait_idle("abort_done");
        check("abort_err", 32'(err_o), 32'd0);

`ifdef SPI_MEM_BRIDGE_STATUS_EN
        ack_en = 1'b0;
        req_q.push_back(mk(1'b1, 3'd0, 16'h0030, 16'h1111));
        f = '{8'h00, 8'h00, 8'h30, 8'h11, 8'h11, 8'h22, 8'h22};
        frame(f, 7);
        ack_en = 1'b1;
        wait_idle("stat_setup");
        cs_low();
        send_byte(8'h8F);
        tx_pulse(8'h80);
        tx_pulse(8'h81);
        cs_high();
        cs_low();
        send_byte(8'h8F);
        tx_pulse(8'h00);
        cs_high();
        @(negedge clk);
        check("stat_err", 32'(err_o), 32'd0);
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("tx_queue_empty", 32'(tx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
